// File: rtl/fft_tw_rotator.sv
// Twiddle rotator for one FFT stage: multiplies each complex sample by the ROM
// twiddle addressed from a per-frame pointer, with round-half-up and saturation.
module fft_tw_rotator #(
    parameter int unsigned stage_FFT      = 2,
    parameter int unsigned word_length    = 16,
    parameter int unsigned word_length_tw = 14
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic signed [word_length-1:0]    in_re,
    input  logic signed [word_length-1:0]    in_im,
    input  logic                             in_last,
    output logic                             en_rd,
    output logic        [stage_FFT-2:0]      rd_ptr_angle,
    input  logic signed [word_length_tw-1:0] cos_data,
    input  logic signed [word_length_tw-1:0] sin_data,
    output logic                             out_valid,
    output logic signed [word_length-1:0]    out_re,
    output logic signed [word_length-1:0]    out_im,
    output logic                             out_last,
    output logic                             frame_err
);

    localparam int unsigned PtrW  = stage_FFT - 1;
    localparam int unsigned ProdW = word_length + word_length_tw;
    localparam int unsigned FullW = ProdW + 1;
    localparam int unsigned Frac  = word_length_tw - 2;

    localparam logic        [PtrW-1:0]  PtrMax  = {PtrW{1'b1}};
    localparam logic signed [FullW-1:0] RndBias = FullW'(1) << (Frac - 1);
    localparam logic signed [FullW-1:0] SatMax  = FullW'((2 ** (word_length - 1)) - 1);
    localparam logic signed [FullW-1:0] SatMin  = ~SatMax;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            frame_err_q, frame_err_d;

    logic                          s1_valid_q, s1_last_q;
    logic signed [word_length-1:0] s1_re_q, s1_im_q;

    logic                    s2_valid_q, s2_last_q;
    logic signed [ProdW-1:0] p_ac_q, p_bs_q, p_as_q, p_bc_q;
    logic signed [ProdW-1:0] p_ac_d, p_bs_d, p_as_d, p_bc_d;

    logic signed [FullW-1:0] re_full, im_full, re_sh, im_sh;

    logic                          out_valid_q, out_last_q;
    logic signed [word_length-1:0] out_re_q, out_im_q;

    function automatic logic signed [word_length-1:0] sat(input logic signed [FullW-1:0] x);
        if (x > SatMax) begin
            return SatMax[word_length-1:0];
        end else if (x < SatMin) begin
            return SatMin[word_length-1:0];
        end
        return x[word_length-1:0];
    endfunction

    assign en_rd        = in_valid;
    assign rd_ptr_angle = ptr_q;

    // A frame end resets the pointer; ending anywhere but the last slot is misaligned.
    always_comb begin
        ptr_d       = ptr_q;
        frame_err_d = frame_err_q;
        if (in_valid) begin
            if (in_last) begin
                ptr_d = '0;
                if (ptr_q != PtrMax) begin
                    frame_err_d = 1'b1;
                end
            end else begin
                ptr_d = ptr_q + PtrW'(1);
            end
        end
    end

    always_comb begin
        p_ac_d = ProdW'(s1_re_q) * ProdW'(cos_data);
        p_bs_d = ProdW'(s1_im_q) * ProdW'(sin_data);
        p_as_d = ProdW'(s1_re_q) * ProdW'(sin_data);
        p_bc_d = ProdW'(s1_im_q) * ProdW'(cos_data);
    end

    // Guard bit absorbs the sum; bias then arithmetic shift gives round-half-up.
    always_comb begin
        re_full = FullW'(p_ac_q) - FullW'(p_bs_q);
        im_full = FullW'(p_as_q) + FullW'(p_bc_q);
        re_sh   = (re_full + RndBias) >>> Frac;
        im_sh   = (im_full + RndBias) >>> Frac;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            frame_err_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            p_ac_q      <= '0;
            p_bs_q      <= '0;
            p_as_q      <= '0;
            p_bc_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            frame_err_q <= frame_err_d;
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_valid) begin
                s1_re_q   <= in_re;
                s1_im_q   <= in_im;
                s1_last_q <= in_last;
            end
            if (s1_valid_q) begin
                p_ac_q    <= p_ac_d;
                p_bs_q    <= p_bs_d;
                p_as_q    <= p_as_d;
                p_bc_q    <= p_bc_d;
                s2_last_q <= s1_last_q;
            end
            if (s2_valid_q) begin
                out_re_q   <= sat(re_sh);
                out_im_q   <= sat(im_sh);
                out_last_q <= s2_last_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_tw_rotator.sv
// Bench for fft_tw_rotator: directed scenarios plus random traffic, checked against
// an integer-arithmetic model of the rotation, pointer and frame rules.
module tb_fft_tw_rotator;

    localparam int Stage = 3;
    localparam int W     = 16;
    localparam int T     = 14;
    localparam int Depth = 4;
    localparam int Frac  = T - 2;

    logic                  clk = 1'b0;
    logic                  rst_n, in_valid, in_last;
    logic signed [W-1:0]   in_re, in_im;
    logic                  en_rd;
    logic [Stage-2:0]      rd_ptr_angle;
    logic signed [T-1:0]   cos_data, sin_data;
    logic                  out_valid, out_last, frame_err;
    logic signed [W-1:0]   out_re, out_im;

    int rom_cos[Depth];
    int rom_sin[Depth];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit last;
        int re;
        int im;
    } ent_t;

    ent_t pipe[3];
    int   m_ptr;
    bit   m_ferr;
    bit   e_valid, e_last;
    int   e_re, e_im;

    always #5 clk = ~clk;

    fft_tw_rotator #(
        .stage_FFT      (Stage),
        .word_length    (W),
        .word_length_tw (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_re        (in_re),
        .in_im        (in_im),
        .in_last      (in_last),
        .en_rd        (en_rd),
        .rd_ptr_angle (rd_ptr_angle),
        .cos_data     (cos_data),
        .sin_data     (sin_data),
        .out_valid    (out_valid),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_last     (out_last),
        .frame_err    (frame_err)
    );

    // Twiddle ROM: one-cycle read latency.
    initial begin
        cos_data = '0;
        sin_data = '0;
    end
    always @(posedge clk) begin
        if (en_rd) begin
            cos_data <= T'(rom_cos[rd_ptr_angle]);
            sin_data <= T'(rom_sin[rd_ptr_angle]);
        end
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic void model_rot(input int a, input int b, input int c, input int s,
                                      output int re, output int im);
        longint r, i;
        r  = longint'(a) * c - longint'(b) * s;
        i  = longint'(a) * s + longint'(b) * c;
        r  = (r + (longint'(1) << (Frac - 1))) >>> Frac;
        i  = (i + (longint'(1) << (Frac - 1))) >>> Frac;
        re = clamp(r);
        im = clamp(i);
    endfunction

    task automatic rom_fill(input int c, input int s);
        for (int k = 0; k < Depth; k++) begin
            rom_cos[k] = c;
            rom_sin[k] = s;
        end
    endtask

    task automatic step(input bit rst, input bit v, input int a, input int b, input bit last);
        ent_t e;
        rst_n    = ~rst;
        in_valid = v;
        in_re    = W'(a);
        in_im    = W'(b);
        in_last  = last;
        #1;
        check("en_rd", en_rd, v);
        if (!rst) check("rd_ptr_angle", rd_ptr_angle, m_ptr);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, last: 1'b0, re: 0, im: 0};
            m_ptr   = 0;
            m_ferr  = 1'b0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_re    = 0;
            e_im    = 0;
        end else begin
            e.v    = v;
            e.last = last;
            model_rot(a, b, rom_cos[m_ptr], rom_sin[m_ptr], e.re, e.im);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
            if (v) begin
                if (last) begin
                    if (m_ptr != Depth - 1) m_ferr = 1'b1;
                    m_ptr = 0;
                end else begin
                    m_ptr = (m_ptr + 1) % Depth;
                end
            end
            e_valid = pipe[2].v;
            if (pipe[2].v) begin
                e_re   = pipe[2].re;
                e_im   = pipe[2].im;
                e_last = pipe[2].last;
            end
        end
        #1;
        check("out_valid", out_valid, e_valid);
        check("out_re", out_re, e_re);
        check("out_im", out_im, e_im);
        check("out_last", out_last, e_last);
        check("frame_err", frame_err, m_ferr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    function automatic int rnd_tw();
        case ($urandom_range(0, 7))
            0:       return -8192;
            1:       return 8191;
            default: return int'($urandom_range(0, 16383)) - 8192;
        endcase
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_re    = '0;
        in_im    = '0;
        m_ptr    = 0;
        rom_fill(0, 0);

        // Reset state
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_err", frame_err, 0);

        // Identity twiddle, pointer walk 0,1,2,3,0
        rom_fill(4096, 0);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        check("ident_valid", out_valid, 1);
        check("ident_re", out_re, 100);
        check("ident_im", out_im, 50);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        check("ptr_wrap", rd_ptr_angle, 1);
        idle(3);

        // -j rotation and saturation
        rom_fill(0, -4096);
        step(1'b0, 1'b1, 100, 50, 1'b0);
        step(1'b0, 1'b1, -32768, -32768, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        check("negj_re", out_re, 50);
        check("negj_im", out_im, -100);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        check("sat_re", out_re, -32768);
        check("sat_im", out_im, 32767);
        idle(2);

        // 45 degrees and round-half-up
        rom_fill(2896, -2896);
        step(1'b0, 1'b1, 4096, 0, 1'b0);
        step(1'b0, 1'b1, 1, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        check("rot45_re", out_re, 2896);
        check("rot45_im", out_im, -2896);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        check("rnd_re", out_re, 1);
        check("rnd_im", out_im, -1);
        idle(2);

        // Gap pattern 1,0,1,1,0 with data changing on idle cycles
        rom_fill(3000, 1500);
        step(1'b0, 1'b1, 1234, -4321, 1'b0);
        step(1'b0, 1'b0, 777, 888, 1'b1);
        step(1'b0, 1'b1, -20000, 15000, 1'b0);
        step(1'b0, 1'b1, 32767, -32768, 1'b0);
        step(1'b0, 1'b0, -5, 5, 1'b0);
        idle(4);

        // Frame alignment: good frame, then short frame
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 10 * k, -7 * k, k == 3);
        check("frame_ok_err", frame_err, 0);
        check("frame_ok_ptr", rd_ptr_angle, 0);
        step(1'b0, 1'b1, 300, 400, 1'b0);
        step(1'b0, 1'b1, 500, 600, 1'b1);
        check("frame_bad_err", frame_err, 1);
        check("frame_bad_ptr", rd_ptr_angle, 0);
        idle(4);
        check("frame_err_sticky", frame_err, 1);

        // Reset with two samples in flight
        step(1'b0, 1'b1, 111, 222, 1'b0);
        step(1'b0, 1'b1, 333, 444, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        check("flush_re", out_re, 0);
        check("flush_err", frame_err, 0);
        idle(4);
        check("flush_valid", out_valid, 0);

        // Random traffic with random twiddles and occasional reset
        for (int k = 0; k < Depth; k++) begin
            rom_cos[k] = rnd_tw();
            rom_sin[k] = rnd_tw();
        end
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 rnd_sample(), rnd_sample(), $urandom_range(0, 5) == 0);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
